pipeline_fetchq: RTL and testbench

Instruction fetch queue between the IF stage and the ID stage of the pipelined MIPS core.
- Buffers up to DEPTH fetched {instr, pc, pcplus4} entries from IF.
- Presents the oldest entry to ID with a valid/ready handshake.
- Backpressures IF through in_ready, which feeds IF's hazard input.
- Flushes all contents on a taken branch (pcsrc).

---
 rtl/pipeline_pkg.sv | 9 +
 rtl/fetchq_ram.sv | 20 ++
 rtl/pipeline_fetchq.sv | 70 +++++++
 tb/tb_pipeline_fetchq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants and fetch-queue entry layout for the pipelined MIPS core
// Entry layout (96 bits): {instr[95:64], pc[63:32], pcplus4[31:0]}
package pipeline_pkg;
    localparam logic [31:0] NOP_INSTR      = 32'h00000000;
    localparam int          FETCHQ_ENTRY_W = 96;
    localparam int          INSTR_LSB      = 64;
    localparam int          PC_LSB         = 32;
    localparam int          PCPLUS4_LSB    = 0;
endpackage

// File: rtl/fetchq_ram.sv
// fetchq_ram: DEPTH x 96 fetch-queue storage, synchronous write, asynchronous read, no reset
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port
module fetchq_ram
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [FETCHQ_ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]             raddr,
    output logic [FETCHQ_ENTRY_W-1:0] rdata
);
    logic [FETCHQ_ENTRY_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/pipeline_fetchq.sv
// pipeline_fetchq: IF-to-ID instruction fetch queue with valid/ready handshake and branch flush
// Ports: clk, reset (async active-low), flush (pcsrc); in_valid/in_ready + in_instr/in_pc/in_pcplus4 from IF;
//        out_valid/out_ready + out_instr/out_pc/out_pcplus4 to ID (zero when !out_valid); count = occupancy
// Option: define FETCHQ_BYPASS_EN for a zero-latency path from IF to ID when the queue is empty
module pipeline_fetchq
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_pcplus4,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_pcplus4,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [FETCHQ_ENTRY_W-1:0] head;
    logic                      byp, take, push, pop, wr_en, rd_en;
`ifdef FETCHQ_BYPASS_EN
    assign byp = (count == '0) & in_valid & ~flush;
`else
    assign byp = 1'b0;
`endif
    // a bypassed entry that ID takes immediately never touches storage
    assign take      = byp & out_ready;
    assign in_ready  = (count < FULL) | out_ready;
    assign out_valid = (count != '0) | byp;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & ~flush & ~take;
    assign rd_en     = pop & ~flush & ~take;
    fetchq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({in_instr, in_pc, in_pcplus4}),
        .raddr (rd_ptr),
        .rdata (head)
    );
    assign out_instr   = !out_valid ? NOP_INSTR : byp ? in_instr   : head[INSTR_LSB +: 32];
    assign out_pc      = !out_valid ? 32'd0     : byp ? in_pc      : head[PC_LSB +: 32];
    assign out_pcplus4 = !out_valid ? 32'd0     : byp ? in_pcplus4 : head[PCPLUS4_LSB +: 32];
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    assert property (@(posedge clk) disable iff (!reset)
        (count <= FULL) && !(rd_en && count == '0) && !(wr_en && !rd_en && count == FULL));
endmodule

// File: tb/tb_pipeline_fetchq.sv
// tb_pipeline_fetchq: directed self-checking bench for pipeline_fetchq
module tb_pipeline_fetchq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_pcplus4 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_pc, out_pcplus4;
    logic [2:0]  count;
    int          total = 0;
    int          bad = 0;

    pipeline_fetchq #(.DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_pcplus4  (in_pcplus4),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pcplus4 (out_pcplus4),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid   = v;
        in_pc      = pc;
        in_instr   = 32'hA000_0000 | pc;
        in_pcplus4 = pc + 32'd4;
        out_ready  = ordy;
        flush      = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr got=%h exp=00000000", out_instr); end
        #9 reset = 1'b1;
        tick();
    endtask

    task automatic test_fill;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL fill_out_pc got=%h exp=00000000", out_pc); end
        total++; if (out_instr !== 32'hA000_0000) begin bad++; $display("FAIL fill_out_instr got=%h exp=a0000000", out_instr); end
        total++; if (out_pcplus4 !== 32'h4) begin bad++; $display("FAIL fill_out_pcplus4 got=%h exp=00000004", out_pcplus4); end
        tick();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_hold_count got=%0d exp=4", count); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL fill_hold_out_pc got=%h exp=00000000", out_pc); end
    endtask

    task automatic test_full_pop;
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fullpop_in_ready got=%b exp=1", in_ready); end
        tick();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fullpop_count got=%0d exp=4", count); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++; if (out_pc !== exp_pc[i]) begin bad++; $display("FAIL drain_out_pc[%0d] got=%h exp=%h", i, out_pc, exp_pc[i]); end
            tick();
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_wrap;
        for (int i = 0; i <= 10; i++) begin
            drive(i < 10, 32'(4 * i), 1'b1, 1'b0);
`ifdef FETCHQ_BYPASS_EN
            if (i < 10) begin
                total++; if (out_pc !== 32'(4 * i)) begin bad++; $display("FAIL wrap_out_pc[%0d] got=%h exp=%h", i, out_pc, 32'(4 * i)); end
            end else begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_tail_valid got=%b exp=0", out_valid); end
            end
`else
            if (i > 0) begin
                total++; if (out_pc !== 32'(4 * (i - 1))) begin bad++; $display("FAIL wrap_out_pc[%0d] got=%h exp=%h", i, out_pc, 32'(4 * (i - 1))); end
                total++; if (count !== 3'd1) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=1", i, count); end
            end
`endif
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_end_count got=%0d exp=0", count); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL wrap_end_out_instr got=%h exp=00000000", out_instr); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        drive(1'b1, 32'h200, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL flush_out_pc got=%h exp=00000000", out_pc); end
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL flush_after_count got=%0d exp=1", count); end
        total++; if (out_pc !== 32'h300) begin bad++; $display("FAIL flush_after_out_pc got=%h exp=00000300", out_pc); end
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_after_drain got=%0d exp=0", count); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        total++; if (count !== 3'd2) begin bad++; $display("FAIL areset_pre_count got=%0d exp=2", count); end
        #1 reset = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL areset_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
        #1 reset = 1'b1;
        tick();
    endtask

    task automatic test_bypass;
        drive(1'b1, 32'h40, 1'b1, 1'b0);
`ifdef FETCHQ_BYPASS_EN
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bypass_out_valid got=%b exp=1", out_valid); end
        total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL bypass_out_pc got=%h exp=00000040", out_pc); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nobypass_out_valid0 got=%b exp=0", out_valid); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL nobypass_count0 got=%0d exp=0", count); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        total++; if (out_pc !== 32'h40) begin bad++; $display("FAIL nobypass_out_pc got=%h exp=00000040", out_pc); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL nobypass_count1 got=%0d exp=1", count); end
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL nobypass_count2 got=%0d exp=0", count); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_pop();
        test_wrap();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
